// File: rtl/mul_round_seq_pkg.sv
// Shared types and sizing helpers for the iterative multiply-and-round sequencer.
package mul_round_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int nsteps(input int width, input int step);
        return width / step;
    endfunction

    // A single-iteration configuration still needs a one-bit counter.
    function automatic int cnt_width(input int width, input int step);
        int n;
        n = nsteps(width, step);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round.sv
// Combinational round-half-to-even of a double-width value down to its upper half.
module round #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0]   x,
    output logic [WIDTH/2-1:0] q
);

    localparam int HW = WIDTH / 2;
    localparam logic [HW-1:0] HALF = {1'b1, {(HW-1){1'b0}}};
    localparam logic [HW-1:0] ONE  = {{(HW-1){1'b0}}, 1'b1};

    logic [HW-1:0] hi_s;
    logic [HW-1:0] lo_s;

    // split into kept half and discarded half, then pick the nearest-even result
    always_comb begin
        hi_s = x[WIDTH-1:HW];
        lo_s = x[HW-1:0];
        if (lo_s > HALF) begin
            q = hi_s + ONE;
        end else if (lo_s == HALF) begin
            q = hi_s + {{(HW-1){1'b0}}, hi_s[0]};
        end else begin
            q = hi_s;
        end
    end

endmodule

// File: rtl/mul_round_seq.sv
// Iterative unsigned fractional multiplier: STEP-bit shift-add over NSTEPS cycles,
// then round-half-to-even to the upper WIDTH bits; one operation in flight.
module mul_round_seq
    import mul_round_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_inexact,
    output logic             busy
);

    localparam int NSTEPS = nsteps(WIDTH, STEP);
    localparam int CW     = cnt_width(WIDTH, STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEPS - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    if ((WIDTH % STEP) != 0) begin : g_bad_step
        $error("mul_round_seq: WIDTH must be a multiple of STEP");
    end

    state_e             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   out_q_r;
    logic               out_inexact_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               busy_r;

    logic [2*WIDTH-1:0] pp_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0]   q_s;
    logic               inexact_s;

    // current multiplier digit times the multiplicand, aligned to the digit's weight
    always_comb begin
        pp_s       = {{WIDTH{1'b0}}, a_r} * {{(2*WIDTH-STEP){1'b0}}, b_r[STEP-1:0]};
        acc_next_s = acc_r + (pp_s << (STEP * int'(cnt_r)));
        inexact_s  = |acc_r[WIDTH-1:0];
    end

    round #(.WIDTH(2*WIDTH)) u_round (
        .x (acc_r),
        .q (q_s)
    );

    // control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            a_r           <= '0;
            b_r           <= '0;
            acc_r         <= '0;
            cnt_r         <= '0;
            out_q_r       <= '0;
            out_inexact_r <= 1'b0;
            out_valid_r   <= 1'b0;
            in_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
        end else if (flush) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= MUL;
                    end
                end
                MUL: begin
                    acc_r <= acc_next_s;
                    b_r   <= b_r >> STEP;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= RND;
                    end
                end
                RND: begin
                    out_q_r       <= q_s;
                    out_inexact_r <= inexact_s;
                    out_valid_r   <= 1'b1;
                    state_r       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_q       = out_q_r;
    assign out_inexact = out_inexact_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mul_round_seq.sv
// Bench for mul_round_seq: directed rounding/abort/backpressure cases plus
// randomized operands on several WIDTH/STEP configurations against an RNE model.
module tb_mul_round_seq;

    localparam int NDUT = 6;
    localparam int DW [NDUT] = '{64, 8, 16, 16, 16, 16};
    localparam int DS [NDUT] = '{4, 2, 1, 2, 4, 16};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_v     [NDUT];
    logic        in_valid_v  [NDUT];
    logic        out_ready_v [NDUT];
    logic [63:0] in_a_v      [NDUT];
    logic [63:0] in_b_v      [NDUT];
    wire  [63:0] out_q_v     [NDUT];
    wire         in_ready_v    [NDUT];
    wire         out_valid_v   [NDUT];
    wire         out_inexact_v [NDUT];
    wire         busy_v        [NDUT];

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    always #5 clk = ~clk;

    mul_round_seq #(.WIDTH(64), .STEP(4)) u_d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a_v[0]), .in_b(in_b_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_q(out_q_v[0]), .out_inexact(out_inexact_v[0]), .busy(busy_v[0])
    );

    mul_round_seq #(.WIDTH(8), .STEP(2)) u_d8 (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a_v[1][7:0]), .in_b(in_b_v[1][7:0]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_q(out_q_v[1][7:0]), .out_inexact(out_inexact_v[1]), .busy(busy_v[1])
    );
    assign out_q_v[1][63:8] = '0;

    for (genvar g = 2; g < NDUT; g++) begin : g_w16
        mul_round_seq #(.WIDTH(16), .STEP(DS[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(flush_v[g]),
            .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
            .in_a(in_a_v[g][15:0]), .in_b(in_b_v[g][15:0]),
            .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
            .out_q(out_q_v[g][15:0]), .out_inexact(out_inexact_v[g]), .busy(busy_v[g])
        );
        assign out_q_v[g][63:16] = '0;
    end

    // Round-half-to-even by biasing with (half - 1 + kept lsb) and truncating.
    function automatic void rne_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] q, output logic inex);
        logic [127:0] p, lsb, bias;
        p    = 128'(a) * 128'(b);
        lsb  = (p >> w) & 128'd1;
        bias = (128'd1 << (w - 1)) - 128'd1 + lsb;
        q    = 64'((p + bias) >> w);
        inex = (p & ((128'd1 << w) - 128'd1)) != 128'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%0d observed=%0b expected=%0b", tag, sel, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        check1("start.in_ready", in_ready_v[sel], 1'b1);
        in_a_v[sel]     = a;
        in_b_v[sel]     = b;
        in_valid_v[sel] = 1'b1;
        tick();
        in_valid_v[sel] = 1'b0;
        in_a_v[sel]     = ~a;
        in_b_v[sel]     = ~b;
        check1("accept.busy", busy_v[sel], 1'b1);
    endtask

    task automatic await_result(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid_v[sel] && n < 400) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic take_result(input logic [63:0] exp_q, input logic exp_x, input int stall);
        check("out_q", out_q_v[sel], exp_q);
        check1("out_inexact", out_inexact_v[sel], exp_x);
        out_ready_v[sel] = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall.out_q", out_q_v[sel], exp_q);
            check1("stall.out_valid", out_valid_v[sel], 1'b1);
        end
        out_ready_v[sel] = 1'b1;
        tick();
        out_ready_v[sel] = 1'b0;
        check1("handoff.out_valid", out_valid_v[sel], 1'b0);
        check1("handoff.in_ready", in_ready_v[sel], 1'b1);
    endtask

    task automatic run_case(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] q, input logic x, input int lat);
        start_op(a, b);
        await_result(lat);
        take_result(q, x, int'($urandom_range(0, 2)));
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | out_valid_v[sel];
        end
        check1(tag, seen, 1'b0);
    endtask

    initial begin
        logic [63:0] a, b, q;
        logic        x;
        int          mode;

        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            flush_v[k] = 1'b0; in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
            in_a_v[k] = '0; in_b_v[k] = '0;
        end
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            sel = k;
            check1("rst.in_ready", in_ready_v[k], 1'b1);
            check1("rst.out_valid", out_valid_v[k], 1'b0);
            check1("rst.busy", busy_v[k], 1'b0);
            check("rst.out_q", out_q_v[k], 64'd0);
            check1("rst.out_inexact", out_inexact_v[k], 1'b0);
        end
        rst_n = 1'b1;
        tick();

        // WIDTH=8 rounding corners: odd-hi tie, even-hi tie, above half, max operands
        sel = 1;
        run_case(64'h30, 64'h08, 64'h02, 1'b1, 5);
        run_case(64'h10, 64'h08, 64'h00, 1'b1, 5);
        run_case(64'h18, 64'h08, 64'h01, 1'b1, 5);
        run_case(64'hFF, 64'hFF, 64'hFE, 1'b1, 5);

        // default configuration, exact product
        sel = 0;
        run_case(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 64'h4000_0000_0000_0000, 1'b0, 17);

        // flush during MUL iteration 5
        start_op(64'h1234_5678_9ABC_DEF1, 64'hFEDC_BA98_7654_3211);
        repeat (4) tick();
        flush_v[0] = 1'b1;
        tick();
        flush_v[0] = 1'b0;
        check1("flush.busy", busy_v[0], 1'b0);
        check1("flush.in_ready", in_ready_v[0], 1'b1);
        check1("flush.out_valid", out_valid_v[0], 1'b0);
        check("flush.out_q_kept", out_q_v[0], 64'h4000_0000_0000_0000);
        watch_no_valid("flush.no_valid", 25);

        // asynchronous reset during MUL iteration 3
        start_op(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check1("arst.in_ready", in_ready_v[0], 1'b1);
        check1("arst.busy", busy_v[0], 1'b0);
        check1("arst.out_valid", out_valid_v[0], 1'b0);
        check("arst.out_q", out_q_v[0], 64'd0);
        check1("arst.out_inexact", out_inexact_v[0], 1'b0);
        #1 rst_n = 1'b1;
        watch_no_valid("arst.no_valid", 25);

        // backpressure with a pending new request held in DONE
        sel = 1;
        start_op(64'hFF, 64'hFF);
        await_result(5);
        in_a_v[1] = 64'h30; in_b_v[1] = 64'h08; in_valid_v[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp.out_q", out_q_v[1], 64'hFE);
            check1("bp.out_valid", out_valid_v[1], 1'b1);
            check1("bp.in_ready", in_ready_v[1], 1'b0);
        end
        out_ready_v[1] = 1'b1;
        tick();
        out_ready_v[1] = 1'b0;
        check1("bp.handoff_valid", out_valid_v[1], 1'b0);
        check1("bp.handoff_in_ready", in_ready_v[1], 1'b1);
        check1("bp.handoff_busy", busy_v[1], 1'b0);
        tick();
        in_valid_v[1] = 1'b0; in_a_v[1] = 64'h00; in_b_v[1] = 64'h00;
        check1("bp.accept_busy", busy_v[1], 1'b1);
        check1("bp.accept_in_ready", in_ready_v[1], 1'b0);
        await_result(5);
        take_result(64'h02, 1'b1, 0);

        // flush coincident with in_valid in IDLE must not accept
        in_a_v[1] = 64'h30; in_b_v[1] = 64'h08; in_valid_v[1] = 1'b1; flush_v[1] = 1'b1;
        tick();
        in_valid_v[1] = 1'b0; flush_v[1] = 1'b0;
        check1("fidle.in_ready", in_ready_v[1], 1'b1);
        check1("fidle.busy", busy_v[1], 1'b0);
        watch_no_valid("fidle.no_valid", 8);

        // randomized WIDTH=16 operands over every STEP configuration
        for (int k = 2; k < NDUT; k++) begin
            sel = k;
            for (int n = 0; n < 400; n++) begin
                mode = int'($urandom_range(0, 7));
                a = 64'($urandom_range(0, 65535));
                b = 64'($urandom_range(0, 65535));
                if (mode == 0) begin
                    a = 64'hFFFF;
                end else if (mode == 1) begin
                    b = 64'h8000;
                end else if (mode == 2) begin
                    b = 64'h0;
                end
                rne_model(DW[k], a, b, q, x);
                run_case(a, b, q, x, DW[k] / DS[k] + 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
